spi_sub_rx: RTL and testbench

Receiving end of the SPI link driven by `spi_main_x2`. Oversamples `sclk`/`mosi`/`csb` on `sys_clk` and deserialises each chip-select frame (2 power-state bits followed by a data word, MSB first). Presents the frame as a parallel word with a one-cycle valid strobe. Used as a behavioural DAC-side receiver in loopback benches and as the input stage of a downstream SPI-controlled block.

---
 rtl/spi_sub_rx.sv | 149 ++++++++++++++
 tb/tb_spi_sub_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_sub_rx.sv
// SPI subordinate receiver: oversamples sclk/mosi/csb on sys_clk and deserialises
// each chip-select frame (2 power-state bits + WORD_WIDTH data bits, MSB first).
module spi_sub_rx #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  csb,
    output logic [WORD_WIDTH-1:0] parallel_out,
    output logic [1:0]            power_state_out,
    output logic                  valid,
    output logic                  frame_err
);

    localparam int FRAME_BITS = WORD_WIDTH + 2;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic sclk_s1_r, sclk_s2_r, sclk_s3_r;
    logic mosi_s1_r, mosi_s2_r;
    logic csb_s1_r, csb_s2_r, csb_s3_r;
    logic post_rst_r, armed_r;
    state_t state_r, state_nx_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [FRAME_BITS-1:0] shreg_r;
    logic [WORD_WIDTH-1:0] parallel_r;
    logic [1:0]            power_state_r;
    logic                  valid_r, frame_err_r;
    logic sclk_rise_s, csb_fall_s, csb_rise_s;
    logic clr_s, shift_s, eval_s;

    // Two-flop synchronisers plus history flop; idle values avoid edges on reset release
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sclk_s1_r <= 1'b0; sclk_s2_r <= 1'b0; sclk_s3_r <= 1'b0;
            mosi_s1_r <= 1'b0; mosi_s2_r <= 1'b0;
            csb_s1_r  <= 1'b1; csb_s2_r  <= 1'b1; csb_s3_r  <= 1'b1;
        end else begin
            sclk_s1_r <= sclk;      sclk_s2_r <= sclk_s1_r; sclk_s3_r <= sclk_s2_r;
            mosi_s1_r <= mosi;      mosi_s2_r <= mosi_s1_r;
            csb_s1_r  <= csb;       csb_s2_r  <= csb_s1_r;  csb_s3_r  <= csb_s2_r;
        end
    end

    assign sclk_rise_s = sclk_s2_r & ~sclk_s3_r;
    assign csb_fall_s  = ~csb_s2_r & csb_s3_r;
    assign csb_rise_s  = csb_s2_r & ~csb_s3_r;

    // Arm frame start only once csb has been seen high from the pin after reset,
    // so a csb held low through reset cannot masquerade as a fresh fall
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            post_rst_r <= 1'b0;
            armed_r    <= 1'b0;
        end else begin
            post_rst_r <= 1'b1;
            armed_r    <= armed_r | (post_rst_r & csb_s1_r);
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and datapath controls; csb rise takes priority over a coincident sclk rise
    always_comb begin
        state_nx_s = state_r;
        clr_s      = 1'b0;
        shift_s    = 1'b0;
        eval_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (csb_fall_s && armed_r) begin
                    state_nx_s = SHIFT;
                    clr_s      = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (csb_rise_s) begin
                    state_nx_s = IDLE;
                    eval_s     = 1'b1;
                end else if (sclk_rise_s) begin
                    shift_s    = 1'b1;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Shift register, saturating bit counter and registered frame outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            shreg_r       <= '0;
            cnt_r         <= '0;
            parallel_r    <= '0;
            power_state_r <= 2'b00;
            valid_r       <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            if (clr_s) begin
                shreg_r <= '0;
                cnt_r   <= '0;
            end else if (shift_s) begin
                if (cnt_r <= CNT_FULL) begin
                    shreg_r <= {shreg_r[FRAME_BITS-2:0], mosi_s2_r};
                end
                if (cnt_r != CNT_SAT) begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else if (eval_s) begin
                if (cnt_r == CNT_FULL) begin
                    power_state_r <= shreg_r[FRAME_BITS-1:FRAME_BITS-2];
                    parallel_r    <= shreg_r[WORD_WIDTH-1:0];
                    valid_r       <= 1'b1;
                end else begin
                    frame_err_r   <= 1'b1;
                end
            end
        end
    end

    assign parallel_out    = parallel_r;
    assign power_state_out = power_state_r;
    assign valid           = valid_r;
    assign frame_err       = frame_err_r;

endmodule

// File: tb/tb_spi_sub_rx.sv
// Directed bench for spi_sub_rx: a frame table plus hand sequences for reset,
// back-to-back, idle sclk and coincident csb/sclk edges.
module tb_spi_sub_rx;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        csb = 1'b1;
    logic [15:0] parallel_out;
    logic [1:0]  power_state_out;
    logic        valid, frame_err;

    int total = 0;
    int bad = 0;
    int vcount = 0;
    int ecount = 0;
    int wide = 0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;

    spi_sub_rx #(.WORD_WIDTH(16)) dut (
        .sys_clk(sys_clk), .rst(rst), .sclk(sclk), .mosi(mosi), .csb(csb),
        .parallel_out(parallel_out), .power_state_out(power_state_out),
        .valid(valid), .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse counters and strobe-width watch, sampled mid-cycle
    always @(negedge sys_clk) begin
        if (valid) vcount <= vcount + 1;
        if (frame_err) ecount <= ecount + 1;
        if ((valid && prev_v) || (frame_err && prev_e) || (valid && frame_err)) wide <= wide + 1;
        prev_v <= valid;
        prev_e <= frame_err;
    end

    typedef struct {
        int          nbits;
        logic [31:0] bits;
        logic        exp_v;
        logic [1:0]  exp_ps;
        logic [15:0] exp_d;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        cyc(1);
        sclk = 1'b1;
        cyc(2);
        sclk = 1'b0;
        cyc(1);
    endtask

    task automatic frame_body(input int n, input logic [31:0] bits);
        csb = 1'b0;
        cyc(2);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
        cyc(2);
    endtask

    // Raise csb and record valid/frame_err over the next five edges; a strobe is due on the third
    task automatic close_and_trace(output logic [4:0] vt, output logic [4:0] et);
        csb = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            vt[k] = valid;
            et[k] = frame_err;
        end
        #1;
    endtask

    logic [4:0] vt, et;
    int v0, e0;

    initial begin
        vecs[0] = '{18, 32'h0003_a5a5, 1'b1, 2'b11, 16'ha5a5};
        vecs[1] = '{18, 32'h0001_04d8, 1'b1, 2'b01, 16'h04d8};
        vecs[2] = '{10, 32'h0000_02a5, 1'b0, 2'b01, 16'h04d8};
        vecs[3] = '{20, 32'h000f_bcde, 1'b0, 2'b01, 16'h04d8};
        vecs[4] = '{18, 32'h0000_ffff, 1'b1, 2'b00, 16'hffff};
        vecs[5] = '{0,  32'h0000_0000, 1'b0, 2'b00, 16'hffff};
        vecs[6] = '{18, 32'h0002_8001, 1'b1, 2'b10, 16'h8001};

        // Reset with random pins
        for (int i = 0; i < 3; i++) begin
            sclk = 1'($urandom);
            mosi = 1'($urandom);
            csb  = 1'($urandom);
            cyc(1);
        end
        @(negedge sys_clk);
        chk("rst_data", 32'(parallel_out), 32'h0);
        chk("rst_ps", 32'(power_state_out), 32'h0);
        chk("rst_strobes", {30'h0, valid, frame_err}, 32'h0);
        sclk = 1'b0;
        mosi = 1'b0;
        csb  = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(10);
        chk("post_rst_pulses", 32'(vcount + ecount), 32'h0);

        // Frame table
        for (int i = 0; i < 7; i++) begin
            frame_body(vecs[i].nbits, vecs[i].bits);
            close_and_trace(vt, et);
            chk($sformatf("vec%0d_valid_trace", i), 32'(vt), vecs[i].exp_v ? 32'h4 : 32'h0);
            chk($sformatf("vec%0d_err_trace", i), 32'(et), vecs[i].exp_v ? 32'h0 : 32'h4);
            chk($sformatf("vec%0d_ps", i), 32'(power_state_out), 32'(vecs[i].exp_ps));
            chk($sformatf("vec%0d_data", i), 32'(parallel_out), 32'(vecs[i].exp_d));
        end

        // Back-to-back frames with a 2-cycle csb-high gap
        v0 = vcount;
        e0 = ecount;
        frame_body(18, 32'h0003_a5a5);
        csb = 1'b1;
        cyc(2);
        frame_body(18, 32'h0001_04d8);
        csb = 1'b1;
        cyc(8);
        chk("b2b_valid_count", 32'(vcount - v0), 32'd2);
        chk("b2b_err_count", 32'(ecount - e0), 32'd0);
        chk("b2b_ps", 32'(power_state_out), 32'h1);
        chk("b2b_data", 32'(parallel_out), 32'h04d8);

        // sclk toggling while csb is high
        v0 = vcount;
        e0 = ecount;
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b1;
            cyc(2);
            sclk = 1'b0;
            cyc(2);
        end
        cyc(6);
        chk("idle_pulses", 32'(vcount - v0 + ecount - e0), 32'd0);
        chk("idle_data", 32'(parallel_out), 32'h04d8);
        chk("idle_ps", 32'(power_state_out), 32'h1);

        // Reset after 8 bits with csb held low
        csb = 1'b0;
        cyc(2);
        for (int i = 0; i < 8; i++) send_bit(1'(i));
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("midrst_data", 32'(parallel_out), 32'h0);
        chk("midrst_ps", 32'(power_state_out), 32'h0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        cyc(2);
        close_and_trace(vt, et);
        chk("midrst_valid_trace", 32'(vt), 32'h0);
        chk("midrst_err_trace", 32'(et), 32'h0);
        frame_body(18, 32'h0002_1234);
        close_and_trace(vt, et);
        chk("after_rst_valid_trace", 32'(vt), 32'h4);
        chk("after_rst_ps", 32'(power_state_out), 32'h2);
        chk("after_rst_data", 32'(parallel_out), 32'h1234);

        // 18th sclk rise lands in the same cycle as the csb rise
        frame_body(17, 32'h0001_5555);
        mosi = 1'b1;
        cyc(1);
        sclk = 1'b1;
        close_and_trace(vt, et);
        sclk = 1'b0;
        cyc(2);
        chk("simul_err_trace", 32'(et), 32'h4);
        chk("simul_valid_trace", 32'(vt), 32'h0);
        chk("simul_ps", 32'(power_state_out), 32'h2);
        chk("simul_data", 32'(parallel_out), 32'h1234);

        chk("strobe_width", 32'(wide), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
